// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: write side, read side, status and error flags.
// The master modport belongs to whoever feeds and drains the FIFO; slave is the FIFO itself.
interface sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              w_afull;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_empty;
  logic              r_aempty;
  logic [ADDR_W:0]   count;
  logic              clr_err;
  logic              overflow;
  logic              underflow;

  modport master (
    output w_en, w_data, r_en, clr_err,
    input  w_full, w_afull, r_data, r_valid, r_empty, r_aempty, count, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en, clr_err,
    output w_full, w_afull, r_data, r_valid, r_empty, r_aempty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO around an inferred simple dual-port RAM with a registered read port.
// The occupancy counter drives every status flag; flags are registered from the next count.
module sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int AFULL_TH  = 2**ADDR_W - 4,
  parameter int AEMPTY_TH = 4
) (
  input logic       clk,
  input logic       rst,
  sync_fifo_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] r_data;
  logic              w_full;
  logic              w_afull;
  logic              r_empty;
  logic              r_aempty;
  logic              r_valid;
  logic              overflow;
  logic              underflow;
  logic              wa;
  logic              ra;

  // Accepts use the registered flags only, so a write at full or a read at empty is simply rejected.
  assign wa = bus.w_en & ~w_full;
  assign ra = bus.r_en & ~r_empty;

  always_comb begin
    count_next = count;
    if (wa && !ra) begin
      count_next = count + CNT_W'(1);
    end else if (ra && !wa) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Storage array is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wa && !rst) begin
      mem[wptr] <= bus.w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (ra) begin
      r_data <= mem[rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      w_full    <= 1'b0;
      w_afull   <= 1'b0;
      r_empty   <= 1'b1;
      r_aempty  <= 1'b1;
      r_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (ra) begin
        rptr <= rptr + ADDR_W'(1);
      end
      count    <= count_next;
      w_full   <= (count_next == FULL_CNT);
      w_afull  <= (count_next >= AFULL_CNT);
      r_empty  <= (count_next == '0);
      r_aempty <= (count_next <= AEMPTY_CNT);
      r_valid  <= ra;
      // A fresh error outranks a simultaneous clear so no event is ever lost.
      if (bus.w_en && w_full) begin
        overflow <= 1'b1;
      end else if (bus.clr_err) begin
        overflow <= 1'b0;
      end
      if (bus.r_en && r_empty) begin
        underflow <= 1'b1;
      end else if (bus.clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  assign bus.w_full    = w_full;
  assign bus.w_afull   = w_afull;
  assign bus.r_empty   = r_empty;
  assign bus.r_aempty  = r_aempty;
  assign bus.r_data    = r_data;
  assign bus.r_valid   = r_valid;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// Randomised scoreboard bench for sync_fifo (16 x 8) against a queue-based reference model.
module tb_sync_fifo;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 4;

  logic clk;
  logic rst;

  sync_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sync_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_rdata;
  bit         m_rvalid;
  bit         m_ovf;
  bit         m_unf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int n;
    n = mq.size();
    cmp("count",     32'(bus.count),    32'(n));
    cmp("w_full",    32'(bus.w_full),   32'(n == DEPTH));
    cmp("w_afull",   32'(bus.w_afull),  32'(n >= AFULL_TH));
    cmp("r_empty",   32'(bus.r_empty),  32'(n == 0));
    cmp("r_aempty",  32'(bus.r_aempty), 32'(n <= AEMPTY_TH));
    cmp("r_valid",   32'(bus.r_valid),  32'(m_rvalid));
    cmp("r_data",    32'(bus.r_data),   32'(m_rdata));
    cmp("overflow",  32'(bus.overflow), 32'(m_ovf));
    cmp("underflow", 32'(bus.underflow), 32'(m_unf));
  endtask

  // Drive one cycle of inputs, advance the reference model, then check status after the edge.
  task automatic applyStimulus(input bit rs, input bit we, input logic [7:0] wd,
                               input bit re, input bit ce);
    bit full;
    bit empty;
    @(negedge clk);
    rst         = rs;
    bus.w_en    = we;
    bus.w_data  = wd;
    bus.r_en    = re;
    bus.clr_err = ce;
    if (rs) begin
      mq.delete();
      m_rdata  = 8'h00;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      m_rvalid = re && !empty;
      if (re && !empty) begin
        m_rdata = mq.pop_front();
        exp_q.push_back(m_rdata);
      end
      if (we && !full) mq.push_back(wd);
      if (we && full) m_ovf = 1'b1;
      else if (ce)    m_ovf = 1'b0;
      if (re && empty) m_unf = 1'b1;
      else if (ce)     m_unf = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Monitor: every presented read word must match the oldest outstanding expectation.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.r_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_r_valid", 32'(bus.r_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          cmp("read_word", 32'(bus.r_data), 32'(e));
        end
      end
    end
  end

  initial begin
    int ones;
    rst = 1'b1;
    bus.w_en = 1'b0;
    bus.w_data = '0;
    bus.r_en = 1'b0;
    bus.clr_err = 1'b0;
    m_rdata = 8'h00;
    m_rvalid = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    applyStimulus(1, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);

    // Fill 0x00..0x0F, then one write too many.
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'(i), 0, 0);
    applyStimulus(0, 1, 8'hEE, 0, 0);

    // Drain, then one read too many.
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 8'h00, 1, 0);
    applyStimulus(0, 0, 8'h00, 1, 0);
    cmp("hold_last_word", 32'(bus.r_data), 32'h0F);

    // Simultaneous write/read at full, then at empty.
    applyStimulus(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'($urandom), 0, 0);
    applyStimulus(0, 1, 8'h77, 1, 0);
    cmp("full_simul_count", 32'(bus.count), 32'd15);
    applyStimulus(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 8'h00, 1, 0);
    applyStimulus(0, 1, 8'h3C, 1, 0);
    cmp("empty_simul_count", 32'(bus.count), 32'd1);
    cmp("empty_simul_rvalid", 32'(bus.r_valid), 32'd0);

    // Error clear, then clear racing a fresh overflow.
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 8'($urandom), 0, 0);
    applyStimulus(0, 1, 8'h11, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1);
    cmp("clr_alone", 32'(bus.overflow), 32'd0);
    applyStimulus(0, 1, 8'h22, 0, 1);
    cmp("set_beats_clr", 32'(bus.overflow), 32'd1);

    // Mid-operation reset with 7 words stored.
    applyStimulus(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 8'($urandom), 0, 0);
    applyStimulus(1, 1, 8'h99, 1, 0);
    applyStimulus(0, 1, 8'hA5, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0);
    cmp("after_reset_word", 32'(bus.r_data), 32'hA5);

    // Stream at occupancy 5 across pointer wrap.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 1, 8'($urandom), 1, 0);
      cmp("stream_count", 32'(bus.count), 32'd5);
    end

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 500; i++) begin
      ones = ((i / 60) % 2 == 0) ? 75 : 25;
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < ones),
                    8'($urandom),
                    ($urandom_range(0, 99) < (100 - ones)),
                    ($urandom_range(0, 19) == 0));
    end

    applyStimulus(0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    cmp("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
